// File: rtl/uart_tx_packet_if.sv
// uart_tx_packet_if: request/mux bundle between frame assembler and transmitter.
// master drives rq, data; slave drives sel, busy, done.
interface uart_tx_packet_if #(
    parameter int NBYTES    = 8,
    parameter int DATA_BITS = 8
);
    localparam int SEL_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic                 rq;
    logic [DATA_BITS-1:0] data;
    logic [SEL_W-1:0]     sel;
    logic                 busy;
    logic                 done;

    modport master (
        output rq,
        output data,
        input  sel,
        input  busy,
        input  done
    );

    modport slave (
        input  rq,
        input  data,
        output sel,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_tx_packet.sv
// uart_tx_packet: RS-485 packet transmitter, NBYTES bytes read through sel/data.
// Ports: clk, reset (sync, high), bus (rq/data/sel/busy/done), tx, dir_tx, dir_rx.
module uart_tx_packet #(
    parameter int NBYTES    = 8,
    parameter int DATA_BITS = 8,
    parameter int MSB_FIRST = 0,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int BAUD_DIV  = 1,
    parameter int DIR_GAP   = 15
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_packet_if.slave bus,
    output logic            tx,
    output logic            dir_tx,
    output logic            dir_rx
);
    localparam int SEL_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int PAR_N = (PARITY != 0) ? 1 : 0;
    localparam int FB    = 1 + DATA_BITS + PAR_N + STOP_BITS;
    localparam int BIT_W = $clog2(FB);
    localparam int CNT_W = $clog2(2 * DIR_GAP);

    localparam logic [CNT_W-1:0] GAP_A     = CNT_W'(DIR_GAP - 1);
    localparam logic [CNT_W-1:0] GAP_B     = CNT_W'(2 * DIR_GAP - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FB - 1);
    localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NBYTES - 1);

    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_packet: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_packet: STOP_BITS must be 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
        $error("uart_tx_packet: DATA_BITS must be 5..8");
    end
    if (NBYTES < 1 || NBYTES > 256) begin : g_bad_nbytes
        $error("uart_tx_packet: NBYTES must be 1..256");
    end
    if (BAUD_DIV < 1 || BAUD_DIV > 65535) begin : g_bad_baud
        $error("uart_tx_packet: BAUD_DIV must be 1..65535");
    end
    if (DIR_GAP < 1) begin : g_bad_gap
        $error("uart_tx_packet: DIR_GAP must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_FRAME,
        S_LAG,
        S_REARM
    } state_t;

    state_t               r_state, w_state;
    logic                 r_rq_meta, r_rq_s;
    logic [CNT_W-1:0]     r_cnt, w_cnt;
    logic [15:0]          r_baud, w_baud;
    logic [BIT_W-1:0]     r_bit, w_bit;
    logic [BIT_W-1:0]     w_bit_inc;
    logic [SEL_W-1:0]     r_sel, w_sel;
    logic [DATA_BITS-1:0] r_hold, w_hold;
    logic                 r_tx, w_tx;
    logic                 r_dir_tx, w_dir_tx;
    logic                 r_dir_rx, w_dir_rx;
    logic                 r_busy, w_busy;
    logic                 r_done, w_done;

    // Line level for bit slot b of the current byte.
    function automatic logic bit_value(
        input logic [BIT_W-1:0]     b,
        input logic [DATA_BITS-1:0] d
    );
        logic v;
        v = 1'b1;
        if (b == '0) v = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) begin
            if (b == BIT_W'(i + 1))
                v = (MSB_FIRST != 0) ? d[DATA_BITS-1-i] : d[i];
        end
        if (PARITY != 0 && b == BIT_W'(DATA_BITS + 1))
            v = (^d) ^ (PARITY == 2);
        return v;
    endfunction

    assign w_bit_inc = r_bit + 1'b1;

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_baud   = r_baud;
        w_bit    = r_bit;
        w_sel    = r_sel;
        w_hold   = r_hold;
        w_tx     = r_tx;
        w_dir_tx = r_dir_tx;
        w_dir_rx = r_dir_rx;
        w_busy   = r_busy;
        w_done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_rq_s) begin
                    w_state  = S_LEAD;
                    w_dir_rx = 1'b1;
                    w_busy   = 1'b1;
                    w_cnt    = '0;
                end
            end
            S_LEAD: begin
                w_cnt = r_cnt + 1'b1;
                if (r_cnt == GAP_A) w_dir_tx = 1'b1;
                if (r_cnt == GAP_B) begin
                    w_state = S_FRAME;
                    w_cnt   = '0;
                    w_hold  = bus.data;
                    w_tx    = 1'b0;
                    w_bit   = '0;
                    w_baud  = '0;
                    w_sel   = '0;
                end
            end
            S_FRAME: begin
                if (r_baud != BAUD_LAST) begin
                    w_baud = r_baud + 16'd1;
                end else begin
                    w_baud = '0;
                    if (r_bit != LAST_BIT) begin
                        w_bit = w_bit_inc;
                        w_tx  = bit_value(w_bit_inc, r_hold);
                        // Advance the mux early so it settles before the next start bit.
                        if (w_bit_inc == LAST_BIT)
                            w_sel = (r_sel == LAST_SEL) ? '0 : r_sel + 1'b1;
                    end else if (r_sel == '0) begin
                        // sel already wrapped: that was the final byte.
                        w_state = S_LAG;
                        w_cnt   = '0;
                        w_tx    = 1'b1;
                    end else begin
                        w_bit  = '0;
                        w_tx   = 1'b0;
                        w_hold = bus.data;
                    end
                end
            end
            S_LAG: begin
                w_cnt = r_cnt + 1'b1;
                if (r_cnt == GAP_A) w_dir_tx = 1'b0;
                if (r_cnt == GAP_B) begin
                    w_state  = S_REARM;
                    w_cnt    = '0;
                    w_dir_rx = 1'b0;
                    w_busy   = 1'b0;
                    w_done   = 1'b1;
                end
            end
            S_REARM: begin
                if (!r_rq_s) w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rq_meta <= 1'b0;
            r_rq_s    <= 1'b0;
            r_cnt     <= '0;
            r_baud    <= '0;
            r_bit     <= '0;
            r_sel     <= '0;
            r_hold    <= '0;
            r_tx      <= 1'b1;
            r_dir_tx  <= 1'b0;
            r_dir_rx  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_rq_meta <= bus.rq;
            r_rq_s    <= r_rq_meta;
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_baud    <= w_baud;
            r_bit     <= w_bit;
            r_sel     <= w_sel;
            r_hold    <= w_hold;
            r_tx      <= w_tx;
            r_dir_tx  <= w_dir_tx;
            r_dir_rx  <= w_dir_rx;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    assign tx       = r_tx;
    assign dir_tx   = r_dir_tx;
    assign dir_rx   = r_dir_rx;
    assign bus.sel  = r_sel;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_uart_tx_packet.sv
// tb_uart_tx_packet: cycle-exact scoreboard bench for uart_tx_packet.
// Five parameter sets; one observed vector {tx,dir_tx,dir_rx,busy,done,sel}.
module tb_uart_tx_packet;
    localparam int GAP = 15;
    localparam logic [12:0] IDLE = {1'b1, 4'b0000, 8'h00};

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mem [0:7];
    logic [12:0] sb [$];
    logic [12:0] obs;
    logic [4:0]  tx_w, dtx_w, drx_w;
    logic [2:0]  d3 [0:2];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_sb  = 0;
    int          cur   = 0;

    always #5 clk = ~clk;

    uart_tx_packet_if #(.NBYTES(8), .DATA_BITS(8)) if0 ();
    uart_tx_packet_if #(.NBYTES(1), .DATA_BITS(8)) if1 ();
    uart_tx_packet_if #(.NBYTES(1), .DATA_BITS(8)) if2 ();
    uart_tx_packet_if #(.NBYTES(5), .DATA_BITS(7)) if3 ();
    uart_tx_packet_if #(.NBYTES(1), .DATA_BITS(8)) if4 ();

    // Byte mux; the NBYTES=5 set sees it through a 3-cycle select pipeline.
    assign if0.data = mem[if0.sel];
    assign if1.data = mem[3'(if1.sel)];
    assign if2.data = mem[3'(if2.sel)];
    assign if4.data = mem[3'(if4.sel)];
    always @(posedge clk) begin
        d3[0] <= if3.sel;
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end
    assign if3.data = mem[d3[2]][6:0];

    uart_tx_packet #(.NBYTES(8)) u0 (
        .clk(clk), .reset(rst), .bus(if0),
        .tx(tx_w[0]), .dir_tx(dtx_w[0]), .dir_rx(drx_w[0])
    );
    uart_tx_packet #(.NBYTES(1), .PARITY(1)) u1 (
        .clk(clk), .reset(rst), .bus(if1),
        .tx(tx_w[1]), .dir_tx(dtx_w[1]), .dir_rx(drx_w[1])
    );
    uart_tx_packet #(.NBYTES(1), .PARITY(2)) u2 (
        .clk(clk), .reset(rst), .bus(if2),
        .tx(tx_w[2]), .dir_tx(dtx_w[2]), .dir_rx(drx_w[2])
    );
    uart_tx_packet #(
        .NBYTES(5), .DATA_BITS(7), .STOP_BITS(2), .BAUD_DIV(4)
    ) u3 (
        .clk(clk), .reset(rst), .bus(if3),
        .tx(tx_w[3]), .dir_tx(dtx_w[3]), .dir_rx(drx_w[3])
    );
    uart_tx_packet #(.NBYTES(1), .MSB_FIRST(1)) u4 (
        .clk(clk), .reset(rst), .bus(if4),
        .tx(tx_w[4]), .dir_tx(dtx_w[4]), .dir_rx(drx_w[4])
    );

    always_comb begin
        obs = '0;
        case (cur)
            0: obs = {tx_w[0], dtx_w[0], drx_w[0], if0.busy, if0.done, 8'(if0.sel)};
            1: obs = {tx_w[1], dtx_w[1], drx_w[1], if1.busy, if1.done, 8'(if1.sel)};
            2: obs = {tx_w[2], dtx_w[2], drx_w[2], if2.busy, if2.done, 8'(if2.sel)};
            3: obs = {tx_w[3], dtx_w[3], drx_w[3], if3.busy, if3.done, 8'(if3.sel)};
            4: obs = {tx_w[4], dtx_w[4], drx_w[4], if4.busy, if4.done, 8'(if4.sel)};
            default: obs = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: one expected vector per clock, sampled on the falling edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            logic [12:0] e;
            e = sb.pop_front();
            check($sformatf("sb_u%0d_%0d", cur, n_sb), 32'(obs), 32'(e));
            n_sb++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_vec(input logic t, input logic dt, input logic dr,
                            input logic bz, input logic dn, input int s);
        sb.push_back({t, dt, dr, bz, dn, 8'(s)});
    endtask

    task automatic push_idle(input int n);
        repeat (n) push_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int b,
                                     input int dbits, input int msb, input int par);
        logic p;
        if (b == 0) return 1'b0;
        if (b <= dbits) return (msb != 0) ? d[dbits - b] : d[b - 1];
        if (par != 0 && b == dbits + 1) begin
            p = 1'b0;
            for (int j = 0; j < dbits; j++) p = p ^ d[j];
            return (par == 2) ? ~p : p;
        end
        return 1'b1;
    endfunction

    // Whole expected timeline from the request (2 sync cycles) to the done pulse.
    task automatic push_packet(input int nb, input int dbits, input int msb,
                               input int par, input int stops, input int bdiv);
        int fb;
        int s;
        logic [7:0] d;
        fb = 1 + dbits + ((par != 0) ? 1 : 0) + stops;
        push_idle(2);
        repeat (GAP) push_vec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        repeat (GAP) push_vec(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        for (int k = 0; k < nb; k++) begin
            d = mem[k] & 8'((1 << dbits) - 1);
            for (int b = 0; b < fb; b++) begin
                s = (b == fb - 1) ? (k + 1) % nb : k;
                repeat (bdiv)
                    push_vec(exp_bit(d, b, dbits, msb, par), 1'b1, 1'b1, 1'b1, 1'b0, s);
            end
        end
        repeat (GAP) push_vec(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        repeat (GAP) push_vec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        push_vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20000) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        if0.rq = 1'b0;
        if1.rq = 1'b0;
        if2.rq = 1'b0;
        if3.rq = 1'b0;
        if4.rq = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        repeat (3) step();
        for (int k = 0; k < 5; k++) begin
            cur = k;
            #1;
            check($sformatf("reset_u%0d", k), 32'(obs), 32'(IDLE));
        end
        rst = 1'b0;
        cur = 0;
        step();

        mem[0] = 8'h55; mem[1] = 8'hA3; mem[2] = 8'h00; mem[3] = 8'hFF;
        mem[4] = 8'h01; mem[5] = 8'h80; mem[6] = 8'h7E; mem[7] = 8'hC4;
        step();
        if0.rq = 1'b1;
        push_packet(8, 8, 0, 0, 1, 1);
        drain();
        push_idle(40);
        drain();
        if0.rq = 1'b0;
        push_idle(3);
        drain();
        if0.rq = 1'b1;
        push_packet(8, 8, 0, 0, 1, 1);
        drain();
        push_idle(10);
        drain();
        // Low glitch that no clock edge samples: must not re-arm.
        if0.rq = 1'b0;
        #2;
        if0.rq = 1'b1;
        push_idle(30);
        drain();
        if0.rq = 1'b0;
        push_idle(5);
        drain();

        if0.rq = 1'b1;
        repeat (68) step();
        check("mid_frame_b3", 32'(obs), 32'({1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3}));
        if0.rq = 1'b0;
        rst = 1'b1;
        push_idle(1);
        step();
        rst = 1'b0;
        push_idle(20);
        drain();
        if0.rq = 1'b1;
        rst = 1'b1;
        push_idle(1);
        step();
        rst = 1'b0;
        push_packet(8, 8, 0, 0, 1, 1);
        drain();
        if0.rq = 1'b0;
        push_idle(5);
        drain();

        mem[0] = 8'h07;
        cur = 1;
        step();
        if1.rq = 1'b1;
        push_packet(1, 8, 0, 1, 1, 1);
        drain();
        if1.rq = 1'b0;
        push_idle(5);
        drain();

        cur = 2;
        step();
        if2.rq = 1'b1;
        push_packet(1, 8, 0, 2, 1, 1);
        drain();
        if2.rq = 1'b0;
        push_idle(5);
        drain();

        mem[0] = 8'h15; mem[1] = 8'h6A; mem[2] = 8'h7F;
        mem[3] = 8'h00; mem[4] = 8'h41;
        cur = 3;
        step();
        if3.rq = 1'b1;
        push_packet(5, 7, 0, 0, 2, 4);
        drain();
        if3.rq = 1'b0;
        push_idle(5);
        drain();

        mem[0] = 8'h80;
        cur = 4;
        step();
        if4.rq = 1'b1;
        push_packet(1, 8, 1, 0, 1, 1);
        drain();
        if4.rq = 1'b0;
        push_idle(5);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
